wb_initiator: RTL and testbench
===============================

Name: wb_initiator

Overview:
- Wishbone classic single-transfer bus master: the initiator side of the bus our peripheral responders (timer, UART, GPIO) sit on.
- Accepts one read/write command on a valid/ready interface and runs exactly one Wishbone cycle.
- Returns read data and error status on a valid/ready response interface.
- Used by the debug/loader path and by self-test logic to poke memory-mapped registers without the core.

Parameters:
WB_DATA_WIDTH, 32, data bus width
WB_ADDR_WIDTH, 32, address bus width
WB_SEL_WIDTH, 4, byte-select width (WB_DATA_WIDTH/8)
TIMEOUT_CYCLES, 255, max cycles waited for ack/err before forced error (only with WB_INITIATOR_TIMEOUT_EN)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  command accepted when valid&ready
cmd_we_i  in  1  1=write, 0=read
cmd_addr_i  in  WB_ADDR_WIDTH  byte address
cmd_data_i  in  WB_DATA_WIDTH  write data
cmd_sel_i  in  WB_SEL_WIDTH  byte enables
rsp_valid_o  out  1  response present
rsp_ready_i  in  1  response consumed when valid&ready
rsp_data_o  out  WB_DATA_WIDTH  read data (0 for writes or on error)
rsp_err_o  out  1  bus error or timeout
wb_addr_o  out  WB_ADDR_WIDTH  Wishbone address
wb_data_o  out  WB_DATA_WIDTH  Wishbone write data
wb_we_o  out  1  Wishbone write enable
wb_sel_o  out  WB_SEL_WIDTH  Wishbone select
wb_stb_o  out  1  Wishbone strobe
wb_cyc_o  out  1  Wishbone cycle
wb_ack_i  in  1  Wishbone acknowledge
wb_err_i  in  1  Wishbone error
wb_data_i  in  WB_DATA_WIDTH  Wishbone read data
busy_o  out  1  high in any state except IDLE

Behaviour:
- Clocking/reset: one clock clk_i; rst_ni asynchronous, active-low. Reset forces state IDLE and all outputs to 0, except cmd_ready_o=1. An in-flight cycle is abandoned with no response; cyc/stb drop immediately.
- All outputs are registered, except cmd_ready_o, which is decoded from state (1 only in IDLE).
- FSM states: IDLE, BUS, RSP.
- IDLE:
  - On cmd_valid_i&cmd_ready_o at edge N: latch addr/data/we/sel onto the wb_* outputs and go to BUS.
  - wb_cyc_o=wb_stb_o=1 from cycle N+1.
- BUS:
  - cyc/stb/addr/data/we/sel are held stable until termination.
  - Sampled each edge: wb_err_i=1 → terminate with err. Else wb_ack_i=1 → terminate ok.
  - Ack and err together: err wins.
  - Earliest termination is the first edge after cyc/stb rise (zero-wait responder ack is legal).
- Termination at edge M:
  - cyc/stb=0 from M+1.
  - rsp_valid_o=1 from M+1, state RSP.
  - Read ok: rsp_data_o=wb_data_i sampled at M. Write or error: rsp_data_o=0.
  - rsp_err_o set per above.
- RSP:
  - rsp_valid_o, rsp_data_o and rsp_err_o are held until rsp_valid_o&rsp_ready_i.
  - Then go to IDLE; rsp_valid_o=0 next cycle.
  - cmd_ready_o rises with IDLE, so back-to-back throughput is one transfer per 3+ cycles.
- wb_ack_i/wb_err_i outside BUS are ignored. wb_data_o and wb_addr_o keep their last values in IDLE; wb_we_o and wb_sel_o are cleared to 0.
- No pipelined/burst mode: CTI/BTE are not driven, and the responder sees exactly one strobe per cycle.

Optional Feature:
- Macro WB_INITIATOR_TIMEOUT_EN.
- Defined:
  - Counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to BUS and increments each BUS cycle without ack/err.
  - When it equals TIMEOUT_CYCLES: terminate with rsp_err_o=1, rsp_data_o=0.
  - Ack/err on that same edge takes precedence over the timeout.
  - Extra output port timeout_o (1 bit) is registered alongside the response and held with rsp_valid_o; it is 1 only for timeout terminations.
- Undefined: no counter and no timeout_o port; BUS waits indefinitely.

Decomposition:
- Shared package wb_pkg:
  - state enum (IDLE/BUS/RSP)
  - localparams for default widths
  - the rsp_err encoding
- One natural sub-module, wb_initiator_timeout: loadable up-counter with terminal-count flag, instantiated only under WB_INITIATOR_TIMEOUT_EN.
- The FSM and datapath stay in wb_initiator.

Test Plan:
1. Write: cmd we=1 addr=0x08 data=0xDEADBEEF sel=0xF; responder acks 1 cycle after stb → wb_* fields match; cyc high exactly 1 cycle post-accept; rsp_valid with data=0, err=0.
2. Read: addr=0x00; responder returns 0x12345678 with ack after 3 wait states → cyc held 4 cycles with stable addr; rsp_data=0x12345678, err=0.
3. Error priority: ack and err asserted together on a read → rsp_err=1, rsp_data=0.
4. Response backpressure: rsp_ready_i low for 5 cycles → rsp_valid/data stable; cmd_ready_o=0 throughout; a new cmd is accepted only after the handshake.
5. Reset mid-BUS: assert rst_ni=0 while cyc=1 → cyc/stb/rsp_valid go 0 asynchronously; after release, a fresh read completes normally.
6. Timeout (macro on, TIMEOUT_CYCLES=4): read to a non-acking address → after 4 BUS cycles cyc drops and rsp_err=1, timeout_o=1; ack on the 4th cycle instead → err=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and defaults for the Wishbone classic initiator.
package wb_pkg;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_ADDR_WIDTH     = 32;
    localparam int DEF_SEL_WIDTH      = DEF_DATA_WIDTH / 8;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RSP  = 2'd2
    } state_t;

    localparam logic RSP_OK  = 1'b0;
    localparam logic RSP_ERR = 1'b1;

endpackage

// File: rtl/wb_initiator_timeout.sv
// Loadable up-counter; tc flags that the cycle being counted is the TIMEOUT_CYCLES-th.
// Latency: tc is combinational on the registered count; no backpressure.
module wb_initiator_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic inc,
    output logic tc
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (inc && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

    // cnt counts completed idle bus cycles, so the current one is number cnt+1
    assign tc = (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_initiator.sv
// Single-transfer Wishbone classic master; cmd -> cyc/stb next cycle, rsp the cycle after ack/err,
// rsp held under backpressure, cmd_ready only in IDLE. Optional bus timeout via WB_INITIATOR_TIMEOUT_EN.
module wb_initiator
    import wb_pkg::*;
#(
    parameter int WB_DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int WB_ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int WB_SEL_WIDTH   = DEF_SEL_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic                     cmd_we_i,
    input  logic [WB_ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [WB_DATA_WIDTH-1:0] cmd_data_i,
    input  logic [WB_SEL_WIDTH-1:0]  cmd_sel_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [WB_DATA_WIDTH-1:0] rsp_data_o,
    output logic                     rsp_err_o,
    output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
    output logic [WB_DATA_WIDTH-1:0] wb_data_o,
    output logic                     wb_we_o,
    output logic [WB_SEL_WIDTH-1:0]  wb_sel_o,
    output logic                     wb_stb_o,
    output logic                     wb_cyc_o,
    input  logic                     wb_ack_i,
    input  logic                     wb_err_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
`ifdef WB_INITIATOR_TIMEOUT_EN
    output logic                     timeout_o,
`endif
    output logic                     busy_o
);

    if (WB_SEL_WIDTH * 8 != WB_DATA_WIDTH || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("wb_initiator: WB_SEL_WIDTH must be WB_DATA_WIDTH/8 and TIMEOUT_CYCLES >= 1");
    end

    state_t state;
    logic   accept;
    logic   term_to;
    logic   bus_done;

    assign cmd_ready_o = (state == IDLE);
    assign accept      = cmd_valid_i && cmd_ready_o;

`ifdef WB_INITIATOR_TIMEOUT_EN
    logic to_tc;

    wb_initiator_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .load  (accept),
        .inc   ((state == BUS) && !wb_ack_i && !wb_err_i),
        .tc    (to_tc)
    );

    // a real ack/err on the terminal edge beats the timeout
    assign term_to = (state == BUS) && to_tc && !wb_ack_i && !wb_err_i;
`else
    assign term_to = 1'b0;
`endif

    assign bus_done = wb_err_i || wb_ack_i || term_to;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_err_o   <= RSP_OK;
            wb_addr_o   <= '0;
            wb_data_o   <= '0;
            wb_we_o     <= 1'b0;
            wb_sel_o    <= '0;
            wb_stb_o    <= 1'b0;
            wb_cyc_o    <= 1'b0;
            busy_o      <= 1'b0;
`ifdef WB_INITIATOR_TIMEOUT_EN
            timeout_o   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        wb_addr_o <= cmd_addr_i;
                        wb_data_o <= cmd_data_i;
                        wb_we_o   <= cmd_we_i;
                        wb_sel_o  <= cmd_sel_i;
                        wb_cyc_o  <= 1'b1;
                        wb_stb_o  <= 1'b1;
                        busy_o    <= 1'b1;
                        state     <= BUS;
                    end
                end
                BUS: begin
                    if (bus_done) begin
                        wb_cyc_o    <= 1'b0;
                        wb_stb_o    <= 1'b0;
                        wb_we_o     <= 1'b0;
                        wb_sel_o    <= '0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= (wb_err_i || term_to) ? RSP_ERR : RSP_OK;
                        rsp_data_o  <= (wb_ack_i && !wb_err_i && !wb_we_o) ? wb_data_i : '0;
`ifdef WB_INITIATOR_TIMEOUT_EN
                        timeout_o   <= term_to;
`endif
                        state       <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_initiator.sv
// Table-driven bench for wb_initiator with a response scoreboard and a bus-side responder model.
module tb_wb_initiator;

    logic        clk_i;
    logic        rst_ni;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [31:0] cmd_addr_i;
    logic [31:0] cmd_data_i;
    logic [3:0]  cmd_sel_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic [31:0] wb_addr_o;
    logic [31:0] wb_data_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic [31:0] wb_data_i;
    logic        busy_o;
`ifdef WB_INITIATOR_TIMEOUT_EN
    logic        timeout_o;
`endif

    wb_initiator #(
        .WB_DATA_WIDTH (32),
        .WB_ADDR_WIDTH (32),
        .WB_SEL_WIDTH  (4),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_we_i    (cmd_we_i),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_data_i  (cmd_data_i),
        .cmd_sel_i   (cmd_sel_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .rsp_err_o   (rsp_err_o),
        .wb_addr_o   (wb_addr_o),
        .wb_data_o   (wb_data_o),
        .wb_we_o     (wb_we_o),
        .wb_sel_o    (wb_sel_o),
        .wb_stb_o    (wb_stb_o),
        .wb_cyc_o    (wb_cyc_o),
        .wb_ack_i    (wb_ack_i),
        .wb_err_i    (wb_err_i),
        .wb_data_i   (wb_data_i),
`ifdef WB_INITIATOR_TIMEOUT_EN
        .timeout_o   (timeout_o),
`endif
        .busy_o      (busy_o)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          waits;     // wait states before the responder terminates
        logic        ack;
        logic        err;
        logic [31:0] rdata;
        int          bp;        // cycles rsp_ready is held low
        logic [31:0] exp_data;
        logic        exp_err;
        logic        exp_to;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        to;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] sel, input int waits, input logic ack,
                                input logic err, input logic [31:0] rdata, input int bp,
                                input logic [31:0] exp_data, input logic exp_err,
                                input logic exp_to);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.sel = sel; v.waits = waits;
        v.ack = ack; v.err = err; v.rdata = rdata; v.bp = bp;
        v.exp_data = exp_data; v.exp_err = exp_err; v.exp_to = exp_to;
        return v;
    endfunction

    // Called with all inputs applied at a falling edge while the DUT sits in IDLE.
    task automatic do_xfer(input vec_t v);
        exp_t e;
        int   n;
        chk("cmd_ready_idle", {31'd0, cmd_ready_o}, 32'd1);
        cmd_valid_i = 1'b1;
        cmd_we_i    = v.we;
        cmd_addr_i  = v.addr;
        cmd_data_i  = v.wdata;
        cmd_sel_i   = v.sel;
        e.data = v.exp_data; e.err = v.exp_err; e.to = v.exp_to;
        sb.push_back(e);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        cmd_addr_i  = 32'hFFFF_FFFF;
        cmd_data_i  = 32'h0;
        chk("busy_in_bus", {31'd0, busy_o}, 32'd1);
        chk("cmd_ready_bus", {31'd0, cmd_ready_o}, 32'd0);
        n = 0;
        while (wb_cyc_o && n < 64) begin
            n++;
            chk("bus_stb", {31'd0, wb_stb_o}, 32'd1);
            chk("bus_addr", wb_addr_o, v.addr);
            chk("bus_wdata", wb_data_o, v.wdata);
            chk("bus_we_sel", {27'd0, wb_we_o, wb_sel_o}, {27'd0, v.we, v.sel});
            if (n == v.waits + 1) begin
                wb_ack_i  = v.ack;
                wb_err_i  = v.err;
                wb_data_i = v.rdata;
            end else begin
                wb_ack_i  = 1'b0;
                wb_err_i  = 1'b0;
                wb_data_i = 32'hBAD0_0000 | n;
            end
            @(negedge clk_i);
        end
        wb_ack_i  = 1'b0;
        wb_err_i  = 1'b0;
        wb_data_i = 32'h5A5A_5A5A;
        chk("cyc_len", n, v.waits + 1);
        chk("stb_drop", {31'd0, wb_stb_o}, 32'd0);
        for (int i = 0; i < v.bp; i++) begin
            chk("bp_valid", {31'd0, rsp_valid_o}, 32'd1);
            chk("bp_cmd_ready", {31'd0, cmd_ready_o}, 32'd0);
            chk("bp_data", rsp_data_o, v.exp_data);
            chk("bp_err", {31'd0, rsp_err_o}, {31'd0, v.exp_err});
            cmd_valid_i = 1'b1;     // must not be taken while the response is pending
            wb_ack_i    = 1'b1;     // stray ack/err outside BUS must be ignored
            wb_err_i    = 1'b1;
            @(negedge clk_i);
        end
        cmd_valid_i = 1'b0;
        wb_ack_i    = 1'b0;
        wb_err_i    = 1'b0;
        chk("rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
        rsp_ready_i = 1'b1;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("rsp_data", rsp_data_o, e.data);
            chk("rsp_err", {31'd0, rsp_err_o}, {31'd0, e.err});
`ifdef WB_INITIATOR_TIMEOUT_EN
            chk("rsp_timeout", {31'd0, timeout_o}, {31'd0, e.to});
`endif
        end
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        chk("post_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("post_ready", {31'd0, cmd_ready_o}, 32'd1);
        chk("post_busy", {31'd0, busy_o}, 32'd0);
        chk("post_cyc", {31'd0, wb_cyc_o}, 32'd0);
        chk("post_we_sel", {27'd0, wb_we_o, wb_sel_o}, 32'd0);
        chk("post_addr_kept", wb_addr_o, v.addr);
    endtask

    initial begin
        rst_ni      = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_we_i    = 1'b0;
        cmd_addr_i  = '0;
        cmd_data_i  = '0;
        cmd_sel_i   = '0;
        rsp_ready_i = 1'b0;
        wb_ack_i    = 1'b0;
        wb_err_i    = 1'b0;
        wb_data_i   = '0;

        //       we    addr          wdata          sel   w  ack  err  rdata          bp exp_data       err  to
        vecs.push_back(mk(1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 0, 1'b1, 1'b0, 32'h11111111, 0, 32'h0,        1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 32'h00, 32'h0,        4'hF, 3, 1'b1, 1'b0, 32'h12345678, 0, 32'h12345678, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 32'h04, 32'h0,        4'hF, 1, 1'b1, 1'b1, 32'hAAAA5555, 0, 32'h0,        1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0C, 32'h0,        4'h3, 0, 1'b1, 1'b0, 32'hCAFEF00D, 5, 32'hCAFEF00D, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 32'h20, 32'h01020304, 4'h1, 2, 1'b0, 1'b1, 32'h77777777, 1, 32'h0,        1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 32'h24, 32'hA5A5A5A5, 4'hC, 1, 1'b1, 1'b0, 32'h99999999, 2, 32'h0,        1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 32'h30, 32'h0,        4'hF, 0, 1'b0, 1'b1, 32'h44444444, 0, 32'h0,        1'b1, 1'b0));
`ifdef WB_INITIATOR_TIMEOUT_EN
        vecs.push_back(mk(1'b0, 32'h40, 32'h0,        4'hF, 3, 1'b0, 1'b0, 32'h0,        0, 32'h0,        1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 32'h44, 32'h0,        4'hF, 3, 1'b1, 1'b0, 32'h0BADF00D, 0, 32'h0BADF00D, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 32'h48, 32'h12121212, 4'hF, 3, 1'b0, 1'b1, 32'h0,        0, 32'h0,        1'b1, 1'b0));
`endif

        #1;
        chk("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
        chk("rst_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
        chk("rst_rsp", {30'd0, rsp_valid_o, rsp_err_o}, 32'd0);
        chk("rst_rsp_data", rsp_data_o, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_bus_fields", wb_addr_o | wb_data_o | {27'd0, wb_we_o, wb_sel_o}, 32'd0);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        foreach (vecs[i]) do_xfer(vecs[i]);

        // Reset while a cycle is outstanding: bus drops at once, no response is produced.
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b0;
        cmd_addr_i  = 32'h10;
        cmd_sel_i   = 4'hF;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        chk("mid_cyc_up", {31'd0, wb_cyc_o}, 32'd1);
        repeat (2) @(negedge clk_i);
        chk("mid_cyc_held", {31'd0, wb_cyc_o}, 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
        chk("arst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("arst_busy", {31'd0, busy_o}, 32'd0);
        chk("arst_ready", {31'd0, cmd_ready_o}, 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("arst_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
        do_xfer(mk(1'b0, 32'h14, 32'h0, 4'hF, 1, 1'b1, 1'b0, 32'hFEEDFACE, 0, 32'hFEEDFACE, 1'b0, 1'b0));

        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
